// File: rtl/uart_tx_sched.sv
// uart_tx_sched: arbitrates the shared uart_tx serializer between the one-shot
// boot sync byte (LOAD mode) and OUT bytes queued in a small register FIFO.
module uart_tx_sched #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter logic [7:0]  SYNC_BYTE  = 8'hAA,
  parameter logic [2:0]  MODE_LOAD  = 3'd1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [2:0]            mode,
  input  logic                  out_valid,
  input  logic [7:0]            out_data,
  output logic                  out_ready,
  input  logic                  tx_busy,
  output logic                  tx_start,
  output logic [7:0]            tx_data,
  output logic                  aa_sent,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic                  idle
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StHold,
    StDrain
  } state_e;

  state_e state_q, state_d;

  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  sync_flag_q, sync_flag_d;
  logic                  aa_sent_q, aa_sent_d;

  logic push;
  logic pop;

  // out_ready depends only on the registered count, so a pop on the same edge
  // never opens room for a push on that edge.
  assign out_ready  = (count_q != FULL);
  assign push       = out_valid && out_ready;
  assign fifo_count = count_q;
  assign tx_data    = tx_data_q;
  assign aa_sent    = aa_sent_q;
  assign tx_start   = (state_q == StStart);
  assign idle       = (count_q == '0) && (state_q == StIdle) && !tx_busy;

  // FIFO storage: written on accepted pushes only, no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= out_data;
    end
  end

  // FIFO pointer and occupancy next-state; pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  // Scheduler next-state: sync byte has priority in LOAD, FIFO served otherwise.
  always_comb begin
    state_d     = state_q;
    tx_data_d   = tx_data_q;
    sync_flag_d = sync_flag_q;
    aa_sent_d   = aa_sent_q;
    pop         = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Both paths wait for tx_busy low so a byte left in flight by a reset
        // is never overrun.
        if ((mode == MODE_LOAD) && !aa_sent_q && !tx_busy) begin
          tx_data_d   = SYNC_BYTE;
          sync_flag_d = 1'b1;
          state_d     = StStart;
        end else if ((mode != MODE_LOAD) && (count_q != '0) && !tx_busy) begin
          tx_data_d   = mem_q[rd_ptr_q];
          pop         = 1'b1;
          sync_flag_d = 1'b0;
          state_d     = StStart;
        end
      end
      StStart: begin
        state_d = StHold;
      end
      StHold: begin
        // uart_tx raises tx_busy one cycle after sampling tx_start.
        state_d = StDrain;
      end
      StDrain: begin
        if (!tx_busy) begin
          if (sync_flag_q) begin
            aa_sent_d = 1'b1;
          end
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State, pointer and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      tx_data_q   <= '0;
      sync_flag_q <= 1'b0;
      aa_sent_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      tx_data_q   <= tx_data_d;
      sync_flag_q <= sync_flag_d;
      aa_sent_q   <= aa_sent_d;
    end
  end

endmodule
